sd_spi_cmd_responder: RTL and testbench

//  Card-side end of the RK8E SD link in SPI mode 0: receives 6-byte SD command frames
//  on MOSI, checks CRC7 and framing, presents decoded index/argument to the card-model

---
 rtl/sd_spi_cmd_responder.sv | 166 ++++++++++++++++
 tb/tb_sd_spi_cmd_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_cmd_responder.sv
// rtl/sd_spi_cmd_responder.sv - SD card-side SPI command frame receiver with R1 response
`timescale 1ns/1ps
module sd_spi_cmd_responder #(
    parameter int NCR    = 1,
    parameter bit CRC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [7:0]  r1_base,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_crc_ok,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;
    localparam int GAP_LEN = NCR * 8;

    logic [2:0]  sclkSync;
    logic [1:0]  csSync;
    logic [1:0]  mosiSync;
    logic [1:0]  state;
    logic [5:0]  bitCnt;
    logic [6:0]  crc;
    logic [45:0] frame;
    logic [6:0]  gapCnt;
    logic [3:0]  respCnt;
    logic [7:0]  r1Reg;

    logic        sclkRise;
    logic        sclkFall;
    logic        csActive;
    logic        mosiBit;
    logic [46:0] frameNext;
    logic        crcMatch;
    logic        crcOkEff;

    function automatic logic [6:0] crc7Step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // sclk keeps a third stage so edges are detected on the already-synchronised level
    assign sclkRise  = sclkSync[1] & ~sclkSync[2];
    assign sclkFall  = ~sclkSync[1] & sclkSync[2];
    assign csActive  = ~csSync[1];
    assign mosiBit   = mosiSync[1];
    assign frameNext = {frame, mosiBit};
    assign crcMatch  = (frameNext[7:1] == crc);
    assign crcOkEff  = CRC_EN ? crcMatch : 1'b1;
    assign busy      = (state != HUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclkSync <= 3'b000;
            csSync   <= 2'b11;
            mosiSync <= 2'b11;
        end else begin
            sclkSync <= {sclkSync[1:0], spi_sclk};
            csSync   <= {csSync[0], spi_cs_n};
            mosiSync <= {mosiSync[0], spi_mosi};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            bitCnt     <= 6'd0;
            crc        <= 7'd0;
            frame      <= 46'd0;
            gapCnt     <= 7'd0;
            respCnt    <= 4'd0;
            r1Reg      <= 8'hFF;
            spi_miso   <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_index  <= 6'd0;
            cmd_arg    <= 32'd0;
            cmd_crc_ok <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            if (!csActive) begin
                state    <= HUNT;
                spi_miso <= 1'b1;
                bitCnt   <= 6'd0;
                crc      <= 7'd0;
                gapCnt   <= 7'd0;
                respCnt  <= 4'd0;
            end else begin
                case (state)
                    HUNT: begin
                        if (sclkRise && !mosiBit) begin
                            state  <= CMD;
                            bitCnt <= 6'd1;
                            crc    <= crc7Step(7'd0, 1'b0);
                            frame  <= 46'd0;
                        end
                    end
                    CMD: begin
                        if (sclkRise) begin
                            frame  <= frameNext[45:0];
                            bitCnt <= bitCnt + 6'd1;
                            if (bitCnt < 6'd40)
                                crc <= crc7Step(crc, mosiBit);
                            if (bitCnt == 6'd47) begin
                                bitCnt <= 6'd0;
                                crc    <= 7'd0;
                                if (!frameNext[46] || !frameNext[0]) begin
                                    frame_err <= 1'b1;
                                    state     <= HUNT;
                                end else begin
                                    cmd_valid  <= 1'b1;
                                    cmd_index  <= frameNext[45:40];
                                    cmd_arg    <= frameNext[39:8];
                                    cmd_crc_ok <= crcOkEff;
                                    r1Reg      <= {r1_base[7] & 1'b0, r1_base[6:4],
                                                   r1_base[3] | (CRC_EN & ~crcMatch),
                                                   r1_base[2:0]};
                                    gapCnt     <= 7'd0;
                                    state      <= GAP;
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (sclkFall) begin
                            spi_miso <= 1'b1;
                            if (gapCnt == 7'(GAP_LEN - 1)) begin
                                gapCnt  <= 7'd0;
                                respCnt <= 4'd0;
                                state   <= RESP;
                            end else begin
                                gapCnt <= gapCnt + 7'd1;
                            end
                        end
                    end
                    default: begin
                        // ninth fall closes the last R1 bit period
                        if (sclkFall) begin
                            if (respCnt == 4'd8) begin
                                spi_miso <= 1'b1;
                                state    <= HUNT;
                            end else begin
                                spi_miso <= r1Reg[7];
                                r1Reg    <= {r1Reg[6:0], 1'b1};
                                respCnt  <= respCnt + 4'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_cmd_responder.sv
// tb/tb_sd_spi_cmd_responder.sv - self-checking bench for sd_spi_cmd_responder
`timescale 1ns/1ps
module tb_sd_spi_cmd_responder;

    logic clk = 1'b0;
    logic rst;
    logic sclk;
    logic csn;
    logic mosi;
    logic [7:0] r1b;

    logic        miso[3];
    logic        cmdValid[3];
    logic [5:0]  cmdIndex[3];
    logic [31:0] cmdArg[3];
    logic        crcOk[3];
    logic        frameErr[3];
    logic        busy[3];

    int checks = 0;
    int passes = 0;

    // model state
    logic        pendSet[3];
    logic [5:0]  pendIdx[3];
    logic [31:0] pendArg[3];
    logic        pendOk[3];
    logic [5:0]  heldIdx[3];
    logic [31:0] heldArg[3];
    logic        heldOk[3];
    int          validCnt[3];
    int          errCnt[3];
    logic [7:0]  rxb[3];
    logic [7:0]  lastR1[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sd_spi_cmd_responder #(
            .NCR   (g == 2 ? 4 : 1),
            .CRC_EN(g == 1 ? 1'b0 : 1'b1)
        ) dut (
            .clk       (clk),
            .reset     (rst),
            .spi_sclk  (sclk),
            .spi_cs_n  (csn),
            .spi_mosi  (mosi),
            .spi_miso  (miso[g]),
            .r1_base   (r1b),
            .cmd_valid (cmdValid[g]),
            .cmd_index (cmdIndex[g]),
            .cmd_arg   (cmdArg[g]),
            .cmd_crc_ok(crcOk[g]),
            .frame_err (frameErr[g]),
            .busy      (busy[g])
        );
    end

    function automatic int ncrOf(input int d);
        return (d == 2) ? 4 : 1;
    endfunction

    function automatic bit crcEnOf(input int d);
        return d != 1;
    endfunction

    // CRC7 as polynomial remainder of message * x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                heldIdx[d] = 6'd0;
                heldArg[d] = 32'd0;
                heldOk[d]  = 1'b0;
                pendSet[d] = 1'b0;
            end else begin
                if (cmdValid[d]) begin
                    check($sformatf("cmd_valid_expected_dut%0d", d), 64'(pendSet[d]), 64'd1);
                    heldIdx[d] = pendIdx[d];
                    heldArg[d] = pendArg[d];
                    heldOk[d]  = pendOk[d];
                    pendSet[d] = 1'b0;
                    validCnt[d]++;
                end
                if (frameErr[d]) errCnt[d]++;
            end
            check($sformatf("held_outputs_dut%0d", d),
                  64'({cmdIndex[d], cmdArg[d], crcOk[d]}),
                  64'({heldIdx[d], heldArg[d], heldOk[d]}));
        end
    end

    task automatic xfer(input logic [7:0] tx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #40;
            for (int d = 0; d < 3; d++) rxb[d][i] = miso[d];
            sclk = 1'b1;
            #40;
            sclk = 1'b0;
        end
    endtask

    task automatic sendFrame(input logic [47:0] f, input logic [7:0] r1, input int nRead);
        logic good;
        logic ok;
        logic [7:0] expR1[3];
        int v0[3];
        int e0[3];
        good = f[46] & f[0];
        ok   = (f[7:1] == crc7(f[47:8]));
        r1b  = r1;
        for (int d = 0; d < 3; d++) begin
            v0[d] = validCnt[d];
            e0[d] = errCnt[d];
            expR1[d] = {1'b0, r1[6:4], r1[3] | (crcEnOf(d) & ~ok), r1[2:0]};
            if (good) begin
                pendSet[d] = 1'b1;
                pendIdx[d] = f[45:40];
                pendArg[d] = f[39:8];
                pendOk[d]  = crcEnOf(d) ? ok : 1'b1;
            end
        end
        for (int b = 5; b >= 0; b--) xfer(f[b*8 +: 8]);
        for (int d = 0; d < 3; d++)
            check($sformatf("busy_after_frame_dut%0d", d), 64'(busy[d]), 64'(good));
        for (int j = 0; j < nRead; j++) begin
            xfer(8'hFF);
            for (int d = 0; d < 3; d++) begin
                if (good && j == ncrOf(d)) lastR1[d] = rxb[d];
                check($sformatf("miso_byte%0d_dut%0d", j, d), 64'(rxb[d]),
                      64'((good && j == ncrOf(d)) ? expR1[d] : 8'hFF));
            end
        end
        if (nRead >= 6) begin
            #100;
            for (int d = 0; d < 3; d++) begin
                check($sformatf("valid_count_dut%0d", d), 64'(validCnt[d] - v0[d]), 64'(good));
                check($sformatf("err_count_dut%0d", d), 64'(errCnt[d] - e0[d]), 64'(!good));
                check($sformatf("busy_idle_dut%0d", d), 64'(busy[d]), 64'd0);
            end
        end
    endtask

    initial begin
        int v0;
        for (int d = 0; d < 3; d++) begin
            validCnt[d] = 0;
            errCnt[d]   = 0;
            pendSet[d]  = 1'b0;
            lastR1[d]   = 8'h00;
        end
        rst = 1'b1; csn = 1'b1; sclk = 1'b0; mosi = 1'b1; r1b = 8'h00;
        #23;
        for (int d = 0; d < 3; d++) begin
            check("reset_miso", 64'(miso[d]), 64'd1);
            check("reset_valid_err_busy", 64'({cmdValid[d], frameErr[d], busy[d]}), 64'd0);
            check("reset_idx_arg_ok", 64'({cmdIndex[d], cmdArg[d], crcOk[d]}), 64'd0);
        end
        check("crc7_cmd0_literal", 64'(crc7(40'h40_0000_0000)), 64'h4A);
        check("crc7_cmd8_literal", 64'(crc7(40'h48_0000_01AA)), 64'h43);
        rst = 1'b0;
        #100;
        csn = 1'b0;
        #100;

        // two fill bytes, then CMD0
        xfer(8'hFF);
        xfer(8'hFF);
        for (int d = 0; d < 3; d++) check("fill_miso", 64'(rxb[d]), 64'hFF);
        sendFrame(48'h40_0000_0000_95, 8'h01, 6);
        check("cmd0_r1_literal", 64'(lastR1[0]), 64'h01);
        check("cmd0_ncr4_r1_literal", 64'(lastR1[2]), 64'h01);

        // CMD8
        sendFrame(48'h48_0000_01AA_87, 8'h01, 6);
        check("cmd8_index_literal", 64'(cmdIndex[0]), 64'd8);
        check("cmd8_arg_literal", 64'(cmdArg[0]), 64'h1AA);
        check("cmd8_crc_ok_literal", 64'(crcOk[0]), 64'd1);

        // bad CRC
        sendFrame(48'h40_0000_0000_97, 8'h01, 6);
        check("badcrc_r1_literal", 64'(lastR1[0]), 64'h09);
        check("badcrc_crcoff_r1_literal", 64'(lastR1[1]), 64'h01);
        check("badcrc_crc_ok_literal", 64'({crcOk[0], crcOk[1]}), 64'b01);

        // stop bit 0, then normal CMD0 with different backend status
        sendFrame(48'h40_0000_0000_94, 8'h01, 6);
        check("stoperr_keeps_crc_ok", 64'(crcOk[0]), 64'd0);
        sendFrame(48'h40_0000_0000_95, 8'h05, 6);
        check("cmd0_r1_05_literal", 64'(lastR1[0]), 64'h05);

        // CS abort after 3 bytes of CMD8
        v0 = validCnt[0] + errCnt[0];
        xfer(8'h48);
        xfer(8'h00);
        xfer(8'h00);
        csn = 1'b1;
        #200;
        for (int d = 0; d < 3; d++) check("cs_abort_busy", 64'(busy[d]), 64'd0);
        check("cs_abort_no_pulses", 64'(validCnt[0] + errCnt[0] - v0), 64'd0);
        csn = 1'b0;
        #100;
        sendFrame(48'h40_0000_0000_95, 8'h01, 6);
        check("after_abort_r1_literal", 64'(lastR1[0]), 64'h01);

        // reset during the NCR=4 gap after CMD8
        sendFrame(48'h48_0000_01AA_87, 8'h01, 2);
        check("gap_busy_ncr4", 64'(busy[2]), 64'd1);
        check("gap_index_before_reset", 64'(cmdIndex[2]), 64'd8);
        rst = 1'b1;
        #1;
        check("reset_gap_miso", 64'(miso[2]), 64'd1);
        check("reset_gap_busy", 64'(busy[2]), 64'd0);
        check("reset_gap_index", 64'(cmdIndex[2]), 64'd0);
        check("reset_gap_arg", 64'(cmdArg[2]), 64'd0);
        #39;
        rst = 1'b0;
        #100;
        sendFrame(48'h40_0000_0000_95, 8'h01, 6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
